// File: rtl/bp_me_wormhole_stream_encode_mem_cmd.sv
// Round-robin arbiter + packet register + flit serializer for memory commands onto a wormhole link.
// Header layout assumed here: msg_type in [4:0] (16..31 unsupported), size in [7:5] (bytes = 2^size).
module bp_me_wormhole_stream_encode_mem_cmd #(
  parameter int num_src_p      = 1,
  parameter int data_width_p   = 512,
  parameter int flit_width_p   = 64,
  parameter int cord_width_p   = 7,
  parameter int cid_width_p    = 2,
  parameter int len_width_p    = 4,
  parameter int header_width_p = 74
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_src_p*header_width_p-1:0]    mem_cmd_header_i,
  input  logic [num_src_p*data_width_p-1:0]      mem_cmd_data_i,
  input  logic [num_src_p-1:0]                   mem_cmd_v_i,
  output logic [num_src_p-1:0]                   mem_cmd_ready_and_o,
  input  logic [num_src_p*cord_width_p-1:0]      dst_cord_i,
  input  logic [num_src_p*cid_width_p-1:0]       dst_cid_i,
  input  logic [cord_width_p-1:0]                src_cord_i,
  input  logic [cid_width_p-1:0]                 src_cid_i,
  output logic [flit_width_p-1:0]                link_data_o,
  output logic                                   link_v_o,
  input  logic                                   link_ready_and_i,
  output logic                                   drop_o
);

  localparam int prefix_width_lp = 2*cord_width_p + 2*cid_width_p + len_width_p + header_width_p;
  localparam int max_flits_lp    = (prefix_width_lp + data_width_p + flit_width_p - 1) / flit_width_p;
  localparam int pkt_width_lp    = max_flits_lp * flit_width_p;
  localparam int cnt_width_lp    = (max_flits_lp > 1) ? $clog2(max_flits_lp) : 1;
  localparam int ptr_width_lp    = (num_src_p > 1) ? $clog2(num_src_p) : 1;

  localparam logic [4:0] e_cce_mem_rd    = 5'd0;
  localparam logic [4:0] e_cce_mem_uc_rd = 5'd2;
  localparam logic [4:0] e_cce_mem_pre   = 5'd4;
  localparam logic [4:0] e_cce_mem_lr    = 5'd5;

  if ((max_flits_lp - 1) >= (1 << len_width_p)) begin : g_len_check
    $error("len_width_p cannot hold the maximum packet length");
  end
  if (header_width_p < 8) begin : g_hdr_check
    $error("header_width_p must cover msg_type and size");
  end
  if ((data_width_p % 8) != 0) begin : g_data_check
    $error("data_width_p must be a multiple of 8");
  end

  typedef enum logic [0:0] {e_idle, e_send} state_e;

  state_e                                      state_q, state_d;
  logic [cnt_width_lp-1:0]                     cnt_q, cnt_d;
  logic [ptr_width_lp-1:0]                     ptr_q, ptr_d;
  logic [len_width_p-1:0]                      len_q, len_d;
  logic [max_flits_lp-1:0][flit_width_p-1:0]   pkt_q, pkt_d;
  logic [flit_width_p-1:0]                     link_data_q, link_data_d;
  logic                                        link_v_q, link_v_d;
  logic                                        drop_q, drop_d;

  logic                                        grant_v, upper_v;
  logic [ptr_width_lp-1:0]                     grant_idx, upper_idx, lower_idx, ptr_next;
  logic [header_width_p-1:0]                   header_g;
  logic [data_width_p-1:0]                     data_g, data_masked;
  logic [cord_width_p-1:0]                     cord_g;
  logic [cid_width_p-1:0]                      cid_g;
  logic [4:0]                                  msg_type;
  logic [2:0]                                  msg_size;
  logic                                        supported, has_data, handshake;
  logic [len_width_p-1:0]                      len_new;
  logic [max_flits_lp-1:0][flit_width_p-1:0]   pkt_new;
  int                                          payload_bits, flits_new;

  // First valid channel at or after the pointer wins; otherwise wrap to the lowest valid one.
  always_comb begin
    upper_v   = 1'b0;
    upper_idx = '0;
    lower_idx = '0;
    grant_v   = 1'b0;
    for (int g = num_src_p-1; g >= 0; g--) begin
      if (mem_cmd_v_i[g]) begin
        grant_v   = 1'b1;
        lower_idx = ptr_width_lp'(g);
        if (g >= int'(ptr_q)) begin
          upper_v   = 1'b1;
          upper_idx = ptr_width_lp'(g);
        end
      end
    end
    grant_idx = upper_v ? upper_idx : lower_idx;
    ptr_next  = (grant_idx == ptr_width_lp'(num_src_p-1)) ? '0 : grant_idx + 1'b1;

    header_g = '0;
    data_g   = '0;
    cord_g   = '0;
    cid_g    = '0;
    for (int g = 0; g < num_src_p; g++) begin
      if (grant_idx == ptr_width_lp'(g)) begin
        header_g = mem_cmd_header_i[g*header_width_p +: header_width_p];
        data_g   = mem_cmd_data_i[g*data_width_p +: data_width_p];
        cord_g   = dst_cord_i[g*cord_width_p +: cord_width_p];
        cid_g    = dst_cid_i[g*cid_width_p +: cid_width_p];
      end
    end

    handshake = (state_q == e_idle) && grant_v && !reset_i;
    for (int g = 0; g < num_src_p; g++) begin
      mem_cmd_ready_and_o[g] = handshake && (grant_idx == ptr_width_lp'(g));
    end
  end

  // Packet image of the granted command; payload beyond the command size is forced to zero.
  always_comb begin
    msg_type  = header_g[4:0];
    msg_size  = header_g[7:5];
    supported = !msg_type[4];
    has_data  = supported && !(msg_type == e_cce_mem_rd || msg_type == e_cce_mem_uc_rd
                               || msg_type == e_cce_mem_pre || msg_type == e_cce_mem_lr);
    payload_bits = 0;
    if (has_data) begin
      payload_bits = ((8 << msg_size) > data_width_p) ? data_width_p : (8 << msg_size);
    end
    flits_new = (prefix_width_lp + payload_bits + flit_width_p - 1) / flit_width_p;
    len_new   = len_width_p'(flits_new - 1);

    data_masked = '0;
    for (int i = 0; i < data_width_p; i++) begin
      data_masked[i] = data_g[i] && (i < payload_bits);
    end
    pkt_new = pkt_width_lp'({data_masked, header_g, src_cid_i, src_cord_i, cid_g, len_new, cord_g});
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    pkt_d       = pkt_q;
    link_data_d = link_data_q;
    drop_d      = 1'b0;
    case (state_q)
      e_idle: begin
        if (handshake) begin
          pkt_d = pkt_new;
          len_d = len_new;
          cnt_d = '0;
          ptr_d = ptr_next;
          if (supported) begin
            state_d     = e_send;
            link_data_d = pkt_new[0];
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      e_send: begin
        if (link_ready_and_i) begin
          if (int'(cnt_q) == int'(len_q)) begin
            state_d = e_idle;
          end else begin
            cnt_d       = cnt_q + 1'b1;
            link_data_d = pkt_q[cnt_q + 1'b1];
          end
        end
      end
      default: state_d = e_idle;
    endcase
    link_v_d = (state_d == e_send);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= e_idle;
      cnt_q       <= '0;
      ptr_q       <= '0;
      len_q       <= '0;
      pkt_q       <= '0;
      link_data_q <= '0;
      link_v_q    <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      pkt_q       <= pkt_d;
      link_data_q <= link_data_d;
      link_v_q    <= link_v_d;
      drop_q      <= drop_d;
    end
  end

  assign link_data_o = link_data_q;
  assign link_v_o    = link_v_q;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_bp_me_wormhole_stream_encode_mem_cmd.sv
// Randomized bench for the memory-command wormhole encoder with a packet-level reference model.
module tb_bp_me_wormhole_stream_encode_mem_cmd;
  localparam int NS = 3, DW = 512, FW = 64, CW = 7, IW = 2, LW = 4, HW = 74;

  logic clk_i = 1'b0;
  logic reset_i;
  logic [HW-1:0] hdr [NS];
  logic [DW-1:0] dat [NS];
  logic [CW-1:0] dcord [NS];
  logic [IW-1:0] dcid [NS];
  logic [NS-1:0] v;
  logic [NS*HW-1:0] hdr_flat;
  logic [NS*DW-1:0] dat_flat;
  logic [NS*CW-1:0] cord_flat;
  logic [NS*IW-1:0] cid_flat;
  logic [NS-1:0] mem_cmd_ready_and_o;
  logic [CW-1:0] src_cord;
  logic [IW-1:0] src_cid;
  logic [FW-1:0] link_data_o;
  logic link_v_o, link_ready, drop_o;

  int n_cmp = 0, n_fail = 0;
  logic [FW-1:0] obs_q[$];
  int seen_wait;
  bit timed_out, stall_bad, idle_ready;

  always_comb begin
    hdr_flat = '0; dat_flat = '0; cord_flat = '0; cid_flat = '0;
    for (int c = 0; c < NS; c++) begin
      hdr_flat[c*HW +: HW]  = hdr[c];
      dat_flat[c*DW +: DW]  = dat[c];
      cord_flat[c*CW +: CW] = dcord[c];
      cid_flat[c*IW +: IW]  = dcid[c];
    end
  end

  bp_me_wormhole_stream_encode_mem_cmd #(
    .num_src_p(NS), .data_width_p(DW), .flit_width_p(FW), .cord_width_p(CW),
    .cid_width_p(IW), .len_width_p(LW), .header_width_p(HW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_cmd_header_i(hdr_flat), .mem_cmd_data_i(dat_flat), .mem_cmd_v_i(v),
    .mem_cmd_ready_and_o(mem_cmd_ready_and_o),
    .dst_cord_i(cord_flat), .dst_cid_i(cid_flat),
    .src_cord_i(src_cord), .src_cid_i(src_cid),
    .link_data_o(link_data_o), .link_v_o(link_v_o), .link_ready_and_i(link_ready),
    .drop_o(drop_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1);
  end

  function automatic logic [HW-1:0] make_hdr(input logic [4:0] t, input logic [2:0] s);
    logic [HW-1:0] h;
    h = HW'({$urandom(), $urandom(), $urandom()});
    h[4:0] = t;
    h[7:5] = s;
    return h;
  endfunction

  function automatic void rand_data(input int ch);
    for (int w = 0; w < DW/32; w++) dat[ch][w*32 +: 32] = $urandom();
  endfunction

  // Reads, prefetch and lr carry no data; everything else carries 2^size bytes.
  function automatic int payload_bytes(input logic [4:0] t, input logic [2:0] s);
    case (t)
      5'd0, 5'd2, 5'd4, 5'd5: return 0;
      default: return 1 << s;
    endcase
  endfunction

  function automatic void model(input int ch, output logic [639:0] pkt, output int nflits);
    int b;
    logic [DW-1:0] d;
    b = payload_bytes(hdr[ch][4:0], hdr[ch][7:5]);
    nflits = (96 + 8*b + FW - 1) / FW;
    d = dat[ch];
    for (int i = 0; i < DW; i++) if (i >= 8*b) d[i] = 1'b0;
    pkt = '0;
    pkt[6:0]    = dcord[ch];
    pkt[10:7]   = 4'(nflits - 1);
    pkt[12:11]  = dcid[ch];
    pkt[19:13]  = src_cord;
    pkt[21:20]  = src_cid;
    pkt[95:22]  = hdr[ch];
    pkt[607:96] = d;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
  endtask

  task automatic issue(input int ch, output bit ok);
    ok = 1'b0;
    v[ch] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (mem_cmd_ready_and_o[ch]) ok = 1'b1;
      tick();
      if (ok) break;
    end
    v[ch] = 1'b0;
  endtask

  // mode 0: ready high; mode 1: ready pattern 1,0,0,1; other: random ready.
  task automatic collect(input int mode, input int budget);
    logic [FW-1:0] prev;
    bit prev_stall, seen;
    obs_q.delete();
    timed_out = 1'b1; stall_bad = 1'b0; idle_ready = 1'b0; seen_wait = 0;
    seen = 1'b0; prev_stall = 1'b0; prev = '0;
    for (int k = 0; k < budget; k++) begin
      case (mode)
        0: link_ready = 1'b1;
        1: link_ready = (k % 4 == 0) || (k % 4 == 3);
        default: link_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (link_v_o) begin
        if (prev_stall && link_data_o !== prev) stall_bad = 1'b1;
        seen = 1'b1;
        if (link_ready) obs_q.push_back(link_data_o);
        prev_stall = !link_ready;
        prev = link_data_o;
      end else if (seen) begin
        timed_out = 1'b0;
        idle_ready = |mem_cmd_ready_and_o;
        tick();
        break;
      end else begin
        seen_wait++;
      end
      tick();
    end
    link_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    for (int c = 0; c < NS; c++) hdr[c] = make_hdr(5'd0, 3'd0);
    v = '1;
    tick();
    #1;
    n_cmp++; if (link_v_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_link_v: got %b want 0", link_v_o); end
    n_cmp++; if (link_data_o !== '0) begin n_fail++; $display("[TB] FAIL reset_link_data: got %h want 0", link_data_o); end
    n_cmp++; if (drop_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_drop: got %b want 0", drop_o); end
    n_cmp++; if (mem_cmd_ready_and_o !== '0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 000", mem_cmd_ready_and_o); end
    v = '0;
    tick();
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_read();
    logic [639:0] pkt;
    int nf;
    bit ok;
    hdr[0] = make_hdr(5'd0, 3'd3);
    rand_data(0);
    model(0, pkt, nf);
    issue(0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL read_handshake: got %b want 1", ok); end
    v[0] = 1'b1;
    collect(0, 40);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("[TB] FAIL read_timeout: got %b want 0", timed_out); end
    n_cmp++; if (seen_wait !== 0) begin n_fail++; $display("[TB] FAIL read_latency: got %0d want 0 idle cycles", seen_wait); end
    n_cmp++; if (obs_q.size() !== nf) begin n_fail++; $display("[TB] FAIL read_flit_count: got %0d want %0d", obs_q.size(), nf); end
    for (int i = 0; i < obs_q.size() && i < nf; i++) begin
      n_cmp++; if (obs_q[i] !== pkt[i*FW +: FW]) begin n_fail++; $display("[TB] FAIL read_flit%0d: got %h want %h", i, obs_q[i], pkt[i*FW +: FW]); end
    end
    if (obs_q.size() == 2) begin
      n_cmp++; if (obs_q[0][CW-1:0] !== dcord[0]) begin n_fail++; $display("[TB] FAIL read_cord: got %h want %h", obs_q[0][CW-1:0], dcord[0]); end
      n_cmp++; if (obs_q[1][63:32] !== 32'h0) begin n_fail++; $display("[TB] FAIL read_data_zero: got %h want 0", obs_q[1][63:32]); end
    end
    n_cmp++; if (idle_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL read_ready_after: got %b want 1", idle_ready); end
    v[0] = 1'b0;
    collect(0, 40);
    n_cmp++; if (seen_wait !== 0) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d want 0 idle cycles", seen_wait); end
    n_cmp++; if (obs_q.size() !== nf) begin n_fail++; $display("[TB] FAIL b2b_flit_count: got %0d want %0d", obs_q.size(), nf); end
    for (int i = 0; i < obs_q.size() && i < nf; i++) begin
      n_cmp++; if (obs_q[i] !== pkt[i*FW +: FW]) begin n_fail++; $display("[TB] FAIL b2b_flit%0d: got %h want %h", i, obs_q[i], pkt[i*FW +: FW]); end
    end
  endtask

  task automatic test_write_size8();
    logic [639:0] pkt;
    int nf;
    bit ok;
    hdr[0] = make_hdr(5'd1, 3'd3);
    dat[0] = '1;
    model(0, pkt, nf);
    issue(0, ok);
    collect(0, 40);
    n_cmp++; if (obs_q.size() !== 3) begin n_fail++; $display("[TB] FAIL wr8_flit_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < nf; i++) begin
      n_cmp++; if (obs_q[i] !== pkt[i*FW +: FW]) begin n_fail++; $display("[TB] FAIL wr8_flit%0d: got %h want %h", i, obs_q[i], pkt[i*FW +: FW]); end
    end
    if (obs_q.size() == 3) begin
      n_cmp++; if (obs_q[2][63:32] !== 32'h0) begin n_fail++; $display("[TB] FAIL wr8_upper_zero: got %h want 0", obs_q[2][63:32]); end
    end
  endtask

  task automatic test_write_backpressure();
    logic [639:0] pkt;
    int nf;
    bit ok;
    hdr[0] = make_hdr(5'd1, 3'd6);
    rand_data(0);
    model(0, pkt, nf);
    issue(0, ok);
    collect(1, 80);
    n_cmp++; if (timed_out !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_timeout: got %b want 0", timed_out); end
    n_cmp++; if (obs_q.size() !== 10) begin n_fail++; $display("[TB] FAIL bp_flit_count: got %0d want 10", obs_q.size()); end
    n_cmp++; if (stall_bad !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stall_stable: got %b want 0", stall_bad); end
    for (int i = 0; i < obs_q.size() && i < nf; i++) begin
      n_cmp++; if (obs_q[i] !== pkt[i*FW +: FW]) begin n_fail++; $display("[TB] FAIL bp_flit%0d: got %h want %h", i, obs_q[i], pkt[i*FW +: FW]); end
    end
  endtask

  task automatic test_unsupported();
    bit ok;
    hdr[1] = make_hdr(5'd20, 3'd2);
    issue(1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_handshake: got %b want 1", ok); end
    #1;
    n_cmp++; if (drop_o !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_pulse: got %b want 1", drop_o); end
    n_cmp++; if (link_v_o !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_no_flit0: got %b want 0", link_v_o); end
    tick();
    #1;
    n_cmp++; if (drop_o !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_one_cycle: got %b want 0", drop_o); end
    n_cmp++; if (link_v_o !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_no_flit1: got %b want 0", link_v_o); end
    tick();
    for (int c = 0; c < NS; c++) hdr[c] = make_hdr(5'd0, 3'd0);
    v = '1;
    #1;
    n_cmp++; if (mem_cmd_ready_and_o !== 3'b100) begin n_fail++; $display("[TB] FAIL drop_ptr: got %b want 100", mem_cmd_ready_and_o); end
    v = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int got[$], when[$];
    int ptr_m, exp_ch;
    logic [NS-1:0] vm;
    pulse_reset();
    link_ready = 1'b1;
    for (int c = 0; c < NS; c++) hdr[c] = make_hdr(5'd0, 3'd0);
    v = '1;
    for (int cyc = 0; cyc < 200 && got.size() < 10; cyc++) begin
      #1;
      if (|(mem_cmd_ready_and_o & v)) begin
        for (int c = 0; c < NS; c++) if (mem_cmd_ready_and_o[c]) got.push_back(c);
        when.push_back(cyc);
        if (got.size() == 6) v[1] = 1'b0;
      end
      tick();
    end
    v = '0;
    n_cmp++; if (got.size() !== 10) begin n_fail++; $display("[TB] FAIL rr_grant_count: got %0d want 10", got.size()); end
    ptr_m = 0;
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      vm = (i < 6) ? 3'b111 : 3'b101;
      exp_ch = 0;
      for (int k = 0; k < NS; k++) begin
        if (vm[(ptr_m + k) % NS]) begin exp_ch = (ptr_m + k) % NS; break; end
      end
      ptr_m = (exp_ch + 1) % NS;
      n_cmp++; if (got[i] !== exp_ch) begin n_fail++; $display("[TB] FAIL rr_grant%0d: got %0d want %0d", i, got[i], exp_ch); end
      if (i > 0) begin
        n_cmp++; if (when[i] - when[i-1] !== 3) begin n_fail++; $display("[TB] FAIL rr_spacing%0d: got %0d want 3", i, when[i] - when[i-1]); end
      end
    end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid_packet();
    logic [639:0] pkt;
    int nf;
    bit ok;
    link_ready = 1'b1;
    hdr[1] = make_hdr(5'd1, 3'd6);
    rand_data(1);
    model(1, pkt, nf);
    issue(1, ok);
    repeat (3) tick();
    #1;
    n_cmp++; if (link_data_o !== pkt[3*FW +: FW]) begin n_fail++; $display("[TB] FAIL mid_flit3: got %h want %h", link_data_o, pkt[3*FW +: FW]); end
    reset_i = 1'b1;
    #1;
    n_cmp++; if (link_v_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_v: got %b want 0", link_v_o); end
    tick();
    reset_i = 1'b0;
    hdr[0] = make_hdr(5'd3, 3'd4);
    rand_data(0);
    hdr[1] = make_hdr(5'd0, 3'd0);
    hdr[2] = make_hdr(5'd0, 3'd0);
    v = '1;
    #1;
    n_cmp++; if (mem_cmd_ready_and_o !== 3'b001) begin n_fail++; $display("[TB] FAIL mid_first_grant: got %b want 001", mem_cmd_ready_and_o); end
    tick();
    v = '0;
    model(0, pkt, nf);
    collect(0, 40);
    n_cmp++; if (obs_q.size() !== nf) begin n_fail++; $display("[TB] FAIL mid_flit_count: got %0d want %0d", obs_q.size(), nf); end
    for (int i = 0; i < obs_q.size() && i < nf; i++) begin
      n_cmp++; if (obs_q[i] !== pkt[i*FW +: FW]) begin n_fail++; $display("[TB] FAIL mid_flit%0d: got %h want %h", i, obs_q[i], pkt[i*FW +: FW]); end
    end
  endtask

  task automatic test_random();
    logic [639:0] pkt;
    int nf, ch;
    bit ok;
    for (int n = 0; n < 12; n++) begin
      ch = $urandom_range(0, NS-1);
      hdr[ch] = make_hdr(5'($urandom_range(0, 15)), 3'($urandom_range(0, 6)));
      rand_data(ch);
      dcord[ch] = CW'($urandom());
      dcid[ch] = IW'($urandom());
      model(ch, pkt, nf);
      issue(ch, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rand%0d_handshake: got %b want 1", n, ok); end
      collect(2, 300);
      n_cmp++; if (obs_q.size() !== nf) begin n_fail++; $display("[TB] FAIL rand%0d_flit_count: got %0d want %0d", n, obs_q.size(), nf); end
      n_cmp++; if (stall_bad !== 1'b0) begin n_fail++; $display("[TB] FAIL rand%0d_stall_stable: got %b want 0", n, stall_bad); end
      for (int i = 0; i < obs_q.size() && i < nf; i++) begin
        n_cmp++; if (obs_q[i] !== pkt[i*FW +: FW]) begin n_fail++; $display("[TB] FAIL rand%0d_flit%0d: got %h want %h", n, i, obs_q[i], pkt[i*FW +: FW]); end
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    v = '0;
    link_ready = 1'b0;
    src_cord = CW'($urandom());
    src_cid = IW'($urandom());
    for (int c = 0; c < NS; c++) begin
      dcord[c] = CW'($urandom());
      dcid[c] = IW'($urandom());
      dat[c] = '0;
      hdr[c] = '0;
    end
    test_reset();
    test_read();
    test_write_size8();
    test_write_backpressure();
    test_unsupported();
    test_round_robin();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
